// File: rtl/z80_bus_tracer.sv
// Z80 bus-cycle tracer: snoops strobes, encodes each completed memory/I-O cycle and queues it in a FWFT FIFO.
// Optional timestamp prefix enabled by defining Z80_TRACER_TIMESTAMP_EN.
module z80_bus_tracer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int WRAP   = 0,
  parameter int TS_W   = 16,
`ifdef Z80_TRACER_TIMESTAMP_EN
  localparam int TS_BITS = TS_W,
`else
  localparam int TS_BITS = 0 * TS_W,
`endif
  localparam int REC_W = 2 + ADDR_W + DATA_W + TS_BITS,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dbus_in,
  input  logic [DATA_W-1:0] dbus_out,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              trace_en,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic              clear,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [REC_W-1:0]  rec_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam bit WRAP_EN = (WRAP != 0);

  logic              act_r;
  logic [1:0]        lat_type_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [DATA_W-1:0] lat_data_r;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;

  logic              active_s;
  logic              end_s;
  logic              in_win_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              valid_s;
  logic              drop_s;
  logic              do_write_s;
  logic              adv_rd_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [REC_W-1:0]  rec_s;

`ifdef Z80_TRACER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running cycle counter; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  assign rec_s = {ts_r, lat_type_r, lat_addr_r, lat_data_r};
`else
  assign rec_s = {lat_type_r, lat_addr_r, lat_data_r};
`endif

  // Cycle detection, filtering and FIFO control decisions.
  always_comb begin
    active_s   = (~rd_n | ~wr_n) & (~mreq_n | ~iorq_n);
    end_s      = act_r & ~active_s;
    in_win_s   = (addr_lo <= lat_addr_r) && (lat_addr_r <= addr_hi);
    push_s     = end_s & trace_en & (lat_type_r[1] | in_win_s);
    valid_s    = (count_r != {CNT_W{1'b0}});
    full_s     = (count_r == CNT_W'(DEPTH));
    pop_s      = rec_ready & valid_s;
    drop_s     = push_s & full_s & ~pop_s & ~clear;
    do_write_s = push_s & ~clear & (~full_s | pop_s | WRAP_EN);
    adv_rd_s   = ~clear & (pop_s | (drop_s & WRAP_EN));
    case ({do_write_s, adv_rd_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Previous-cycle activity and per-cycle latch of the bus contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_r      <= 1'b0;
      lat_type_r <= 2'b00;
      lat_addr_r <= {ADDR_W{1'b0}};
      lat_data_r <= {DATA_W{1'b0}};
    end else begin
      act_r <= active_s;
      if (active_s) begin
        lat_type_r <= {~iorq_n, rd_n};
        lat_addr_r <= address;
        lat_data_r <= ~rd_n ? dbus_in : dbus_out;
      end
    end
  end

  // FIFO storage; contents are only observed through count-gated reads.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem[wr_ptr_r] <= rec_s;
    end
  end

  // Pointers, occupancy and drop bookkeeping; clear overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else if (clear) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (adv_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) begin
          drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
      end
    end
  end

  assign rec_valid = valid_s;
  assign rec_data  = valid_s ? mem[rd_ptr_r] : {REC_W{1'b0}};
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Self-checking bench for z80_bus_tracer: queue-level reference model for a stop-on-full and a ring-mode instance.
module tb_z80_bus_tracer;
`ifdef Z80_TRACER_TIMESTAMP_EN
  localparam int TSB = 16;
`else
  localparam int TSB = 0;
`endif
  localparam int RW = 26 + TSB;
  typedef logic [RW-1:0] rec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] address = 16'h0000, addr_lo = 16'h0000, addr_hi = 16'hFFFF;
  logic [7:0] dbus_in = 8'h00, dbus_out = 8'h00;
  logic rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic trace_en = 1'b1, clear = 1'b0, rec_ready = 1'b0;
  logic rv0, rv1, ov0, ov1;
  rec_t rd0, rd1;
  logic [2:0] cnt0, cnt1;
  logic [15:0] dc0, dc1;

  always #5 clk = ~clk;

  z80_bus_tracer #(.DEPTH(4), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .trace_en(trace_en),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .clear(clear), .rec_valid(rv0), .rec_ready(rec_ready),
    .rec_data(rd0), .count(cnt0), .overflow(ov0), .drop_cnt(dc0));

  z80_bus_tracer #(.DEPTH(4), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .trace_en(trace_en),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .clear(clear), .rec_valid(rv1), .rec_ready(rec_ready),
    .rec_data(rd1), .count(cnt1), .overflow(ov1), .drop_cnt(dc1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: records as queue entries, one queue per instance.
  rec_t q0[$], q1[$];
  logic m_ov0 = 1'b0, m_ov1 = 1'b0, m_prev_busy = 1'b0;
  int m_dc0 = 0, m_dc1 = 0;
  logic [1:0] m_type = 2'b00;
  logic [15:0] m_addr = 16'h0000, m_ts = 16'h0000;
  logic [7:0] m_data = 8'h00;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q0.delete(); q1.delete();
        m_ov0 = 1'b0; m_ov1 = 1'b0; m_dc0 = 0; m_dc1 = 0;
        m_prev_busy = 1'b0; m_type = 2'b00; m_addr = 16'h0000; m_data = 8'h00; m_ts = 16'h0000;
      end else begin
        bit busy, take, p0, p1;
        rec_t r;
        busy = (!rd_n || !wr_n) && (!mreq_n || !iorq_n);
        take = m_prev_busy && !busy && trace_en && (m_type[1] || (addr_lo <= m_addr && m_addr <= addr_hi));
        r = rec_t'({m_type, m_addr, m_data});
        if (TSB > 0) r = rec_t'({m_ts, m_type, m_addr, m_data});
        p0 = rec_ready && (q0.size() != 0);
        p1 = rec_ready && (q1.size() != 0);
        if (clear) begin
          q0.delete(); q1.delete();
          m_ov0 = 1'b0; m_ov1 = 1'b0; m_dc0 = 0; m_dc1 = 0;
        end else begin
          if (p0) void'(q0.pop_front());
          if (p1) void'(q1.pop_front());
          if (take) begin
            if (q0.size() < 4) q0.push_back(r);
            else begin m_ov0 = 1'b1; if (m_dc0 < 65535) m_dc0++; end
            if (q1.size() < 4) q1.push_back(r);
            else begin m_ov1 = 1'b1; if (m_dc1 < 65535) m_dc1++; void'(q1.pop_front()); q1.push_back(r); end
          end
        end
        if (busy) begin
          m_type = {!iorq_n, rd_n ? 1'b1 : 1'b0};
          m_addr = address;
          m_data = !rd_n ? dbus_in : dbus_out;
        end
        m_prev_busy = busy;
        m_ts = m_ts + 16'd1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("valid0", rv0, q0.size() != 0);
        chk("data0", rd0, (q0.size() != 0) ? 64'(q0[0]) : 64'd0);
        chk("count0", cnt0, q0.size());
        chk("ovf0", ov0, m_ov0);
        chk("drop0", dc0, m_dc0);
        chk("valid1", rv1, q1.size() != 0);
        chk("data1", rd1, (q1.size() != 0) ? 64'(q1[0]) : 64'd0);
        chk("count1", cnt1, q1.size());
        chk("ovf1", ov1, m_ov1);
        chk("drop1", dc1, m_dc1);
      end
    end
  end

  task automatic bus(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d,
                     input int hold, input bit pop_end, input bit clr_end);
    @(negedge clk);
    address = a;
    if (wr) dbus_out = d; else dbus_in = d;
    mreq_n = io; iorq_n = !io; rd_n = wr; wr_n = !wr;
    repeat (hold) @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rec_ready = pop_end; clear = clr_end;
    @(posedge clk);
    #1;
    rec_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic pop_n(input int n);
    @(negedge clk);
    rec_ready = 1'b1;
    repeat (n) @(negedge clk);
    rec_ready = 1'b0;
  endtask

  logic [25:0] e;
  logic [15:0] t1, t2;

  initial begin
    // Reset state, with a memory write already in progress
    address = 16'h0777; dbus_out = 8'h11; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("rst_valid", rv0, 1'b0); chk("rst_count", cnt0, 3'd0); chk("rst_data", rd0, 64'd0);
    chk("rst_ovf", ov1, 1'b0); chk("rst_drop", dc1, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    e = {2'b01, 16'h0777, 8'h11};
    chk("relearn_count", cnt0, 3'd1); chk("relearn_rec", rd0[25:0], e);
    pop_n(1);

    // Single memory write, visible right after the release edge
    bus(1'b0, 1'b1, 16'h1234, 8'hA5, 1, 1'b0, 1'b0);
    e = {2'b01, 16'h1234, 8'hA5};
    chk("memwr_valid", rv0, 1'b1); chk("memwr_rec", rd0[25:0], e);
    pop_n(1);

    // I/O bypasses the window, memory read outside it does not
    addr_lo = 16'h8000; addr_hi = 16'h8FFF;
    bus(1'b1, 1'b0, 16'h0042, 8'h5A, 2, 1'b0, 1'b0);
    bus(1'b0, 1'b0, 16'h0042, 8'h77, 1, 1'b0, 1'b0);
    e = {2'b10, 16'h0042, 8'h5A};
    chk("io_count", cnt0, 3'd1); chk("io_rec", rd0[25:0], e);
    pop_n(1);
    addr_lo = 16'h0010; addr_hi = 16'h0005;
    bus(1'b0, 1'b1, 16'h0008, 8'h33, 1, 1'b0, 1'b0);
    chk("inv_window", cnt0, 3'd0);
    addr_lo = 16'h0000; addr_hi = 16'hFFFF; trace_en = 1'b0;
    bus(1'b1, 1'b1, 16'h0010, 8'h44, 1, 1'b0, 1'b0);
    chk("trace_off", cnt0, 3'd0);
    trace_en = 1'b1;

    // Six writes into four entries
    for (int i = 1; i <= 6; i++) bus(1'b0, 1'b1, 16'h0100 + 16'(i), 8'(i), 1, 1'b0, 1'b0);
    e = {2'b01, 16'h0101, 8'h01};
    chk("stop_count", cnt0, 3'd4); chk("stop_ovf", ov0, 1'b1); chk("stop_drop", dc0, 16'd2);
    chk("stop_head", rd0[25:0], e);
    e = {2'b01, 16'h0103, 8'h03};
    chk("ring_count", cnt1, 3'd4); chk("ring_drop", dc1, 16'd2); chk("ring_head", rd1[25:0], e);
    bus(1'b0, 1'b1, 16'h0107, 8'h07, 1, 1'b1, 1'b0);
    e = {2'b01, 16'h0104, 8'h04};
    chk("fullpp_count1", cnt1, 3'd4); chk("fullpp_drop1", dc1, 16'd2); chk("fullpp_head1", rd1[25:0], e);
    e = {2'b01, 16'h0102, 8'h02};
    chk("fullpp_count0", cnt0, 3'd4); chk("fullpp_drop0", dc0, 16'd2); chk("fullpp_head0", rd0[25:0], e);
    pop_n(6);
    chk("drained", cnt0, 3'd0);

    // Clear wins over a simultaneous push
    for (int i = 0; i < 3; i++) bus(1'b0, 1'b1, 16'h0200 + 16'(i), 8'h20, 1, 1'b0, 1'b0);
    bus(1'b0, 1'b1, 16'h0300, 8'h30, 1, 1'b0, 1'b1);
    chk("clr_count", cnt0, 3'd0); chk("clr_ovf", ov0, 1'b0); chk("clr_drop", dc1, 16'd0);
    chk("clr_valid", rv0, 1'b0); chk("clr_data", rd0, 64'd0);

    // Asynchronous reset in the middle of a drain
    bus(1'b0, 1'b1, 16'h0400, 8'h40, 1, 1'b0, 1'b0);
    bus(1'b0, 1'b1, 16'h0401, 8'h41, 1, 1'b0, 1'b0);
    @(negedge clk);
    rec_ready = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("amid_valid", rv0, 1'b0); chk("amid_count", cnt0, 3'd0); chk("amid_data", rd0, 64'd0);
    chk("amid_count1", cnt1, 3'd0);
    rec_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

`ifdef Z80_TRACER_TIMESTAMP_EN
    // Back-to-back cycles end two clocks apart
    bus(1'b0, 1'b1, 16'h0500, 8'h50, 1, 1'b0, 1'b0);
    bus(1'b0, 1'b1, 16'h0501, 8'h51, 1, 1'b0, 1'b0);
    t1 = rd0[RW-1:26];
    pop_n(1);
    t2 = rd0[RW-1:26];
    chk("ts_delta", t2 - t1, 16'd2);
    pop_n(1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bus_tracer.md
# z80_bus_tracer

Parametrised Z80 bus-cycle tracer that replaces ad-hoc waveform dumping and host-side bus sampling with an in-fabric capture buffer. It sits beside `z80_system`, snoops its address/data/strobe signals, encodes each completed memory or I/O cycle as a record, and queues it in a configurable-depth FIFO. A consumer (host bridge or UART dumper) drains the records over a valid/ready interface.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4 to 1024.
- `ADDR_W`, 16: captured address width.
- `DATA_W`, 8: captured data width.
- `WRAP`, 0: 0 = stop-on-full (new records dropped); 1 = ring mode (oldest overwritten).
- `TS_W`, 16: timestamp field width (used only with `Z80_TRACER_TIMESTAMP_EN`).

- `clk`  in  1  system clock, same domain as `z80_system`.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  CPU address bus.
- `dbus_in`  in  DATA_W  data into CPU; captured on read cycles.
- `dbus_out`  in  DATA_W  data from CPU; captured on write cycles.
- `rd_n`, `wr_n`, `mreq_n`, `iorq_n`  in  1 each  CPU strobes, active-low.
- `trace_en`  in  1  capture enable.
- `addr_lo`, `addr_hi`  in  ADDR_W each  inclusive memory-cycle address window.
- `clear`  in  1  synchronous flush.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts record.
- `rec_data`  out  REC_W  oldest record; REC_W = 2+ADDR_W+DATA_W (+TS_W with timestamp).
- `count`  out  clog2(DEPTH)+1  records held.
- `overflow`  out  1  sticky: a record was dropped or overwritten.
- `drop_cnt`  out  16  saturating count of dropped/overwritten records.

## Operation
- `active` = (!rd_n | !wr_n) & (!mreq_n | !iorq_n). Register `act_q` holds previous-cycle `active`.
- While `active`, latch every cycle: address, type, data (`dbus_in` if !rd_n, else `dbus_out`).
- Cycle end = `act_q & !active`. At that edge push latched record if `trace_en` and (I/O cycle, or `addr_lo` <= addr <= `addr_hi`). `addr_lo` > `addr_hi` blocks all memory records.
- Record layout MSB→LSB: [timestamp], type[1:0], addr, data. Type: 00 mem rd, 01 mem wr, 10 io rd, 11 io wr. `iorq_n` low takes precedence for type. Interrupt acknowledge (`iorq_n` & M1, no rd/wr) is never recorded.
- FIFO: first-word-fall-through; `rec_data` = mem[rd_ptr] when `count`≠0, else all zeros. Pop when `rec_valid & rec_ready`.
- Full, push, no pop: WRAP=0 drop new; WRAP=1 write and advance rd_ptr. Either way set `overflow`, increment `drop_cnt` (saturate at 0xFFFF).
- Full, push and pop same cycle: both performed, no drop, `count` unchanged.
- Empty, push and pop: pop ignored (`rec_valid` was 0), push stored.
- `clear`: pointers, `count`, `overflow`, `drop_cnt` to zero; beats push and pop same cycle; that cycle's push discarded uncounted.
- Pointers wrap modulo DEPTH; `count` = DEPTH means full.

## Timing
- Reset (async, `reset` low): `rec_valid`=0, `rec_data`=0, `count`=0, `overflow`=0, `drop_cnt`=0, `act_q`=0, timestamp=0. Cycle in progress at reset release is recorded only once its end is seen after release with `act_q` relearned (first active cycle sets `act_q`).
- Latency: strobe release sampled at edge k → record written at edge k → `rec_valid`/`count` updated in cycle after edge k.
- Pop at edge j → next record (or empty) visible after edge j; one record per cycle sustained.
- `overflow`/`drop_cnt` update at the edge of the offending push.
- Minimum bus cycle: one active clock; back-to-back cycles need one inactive clock between them to be split.

## Configuration
- `Z80_TRACER_TIMESTAMP_EN` defined: free-running TS_W-bit cycle counter (wraps, cleared by reset only, not `clear`); its value at the cycle-end edge is prepended to each record; REC_W includes TS_W.
- Undefined: no counter, REC_W = 2+ADDR_W+DATA_W.

## Test plan
- Mem write 0x1234←0xA5, window 0x0000–0xFFFF -> one record type 01, addr 0x1234, data 0xA5, `rec_valid` one cycle after strobe release.
- IO read port 0x0042 returning 0x5A with window 0x8000–0x8FFF -> recorded (type 10, data 0x5A); mem read at 0x0042 in same run -> not recorded.
- DEPTH=4, WRAP=0, 6 writes, no pops -> `count`=4, records 1–4 retained, `overflow`=1, `drop_cnt`=2.
- DEPTH=4, WRAP=1, 6 writes -> records 3–6 retained in order, `drop_cnt`=2; full plus simultaneous pop/push -> `count` stays 4, `drop_cnt` unchanged.
- `clear` asserted same cycle as a push with 3 records held -> `count`=0, `overflow`=0, pushed record absent.
- Async `reset` low mid-drain with 2 records -> outputs zero immediately; with timestamp enabled, record timestamps differ by exact clock counts between cycle ends.
